// File: rtl/nfca_tx_frame.sv
// NFC-A (ISO14443A) PCD->PICC frame transmitter: byte stream in, odd parity,
// SOF/EOF framing and Modified-Miller pause encoding at 106 kbps on tx_pause.
module nfca_tx_frame #(
  parameter int BIT_CLKS   = 768,
  parameter int PAUSE_CLKS = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_short,
  output logic       tx_pause,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  // state   | meaning
  // IDLE    | waiting for the first byte of a frame
  // SOF     | start of communication, one Z slot
  // DATA    | data bits, LSB first (7 bits for short frames)
  // PAR     | odd parity slot; next byte may be taken here
  // EOF0    | logic-0 slot closing the frame
  // EOF1    | silent Y slot, then done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_SOF, ST_DATA, ST_PAR, ST_EOF0, ST_EOF1
  } state_t;

  localparam int CW = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] CNT_END = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] X_BEG   = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] X_END   = CW'(BIT_CLKS / 2 + PAUSE_CLKS);
  localparam logic [CW-1:0] Z_END   = CW'(PAUSE_CLKS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          short_q, short_d;
  logic          prev_q, prev_d;
  logic          err_q, err_d;
  logic [7:0]    nxt_data_q, nxt_data_d;
  logic          nxt_last_q, nxt_last_d;
  logic          nxt_vld_q, nxt_vld_d;
  logic          ready_d, pause_d, busy_d, done_d, txerr_d;
  logic          hs, slot_end, cur_bit, new_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      short_q    <= 1'b0;
      prev_q     <= 1'b0;
      err_q      <= 1'b0;
      nxt_data_q <= '0;
      nxt_last_q <= 1'b0;
      nxt_vld_q  <= 1'b0;
      s_ready    <= 1'b0;
      tx_pause   <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      last_q     <= last_d;
      short_q    <= short_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      nxt_data_q <= nxt_data_d;
      nxt_last_q <= nxt_last_d;
      nxt_vld_q  <= nxt_vld_d;
      s_ready    <= ready_d;
      tx_pause   <= pause_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
      tx_err     <= txerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    last_d     = last_q;
    short_d    = short_q;
    prev_d     = prev_q;
    err_d      = err_q;
    nxt_data_d = nxt_data_q;
    nxt_last_d = nxt_last_q;
    nxt_vld_d  = nxt_vld_q;
    done_d     = 1'b0;
    txerr_d    = 1'b0;
    hs         = s_valid & s_ready;
    slot_end   = (cnt_q == CNT_END);

    case (state_q)
      ST_DATA: cur_bit = data_q[bit_q];
      ST_PAR:  cur_bit = ~^data_q;
      default: cur_bit = 1'b0;
    endcase

    if (state_q != ST_IDLE)
      cnt_d = slot_end ? '0 : cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          data_d  = s_data;
          last_d  = s_last | s_short;
          short_d = s_short;
          err_d   = 1'b0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = ST_SOF;
        end
      end
      ST_SOF: begin
        if (slot_end) begin
          prev_d  = 1'b0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (slot_end) begin
          prev_d = cur_bit;
          if (bit_q == (short_q ? 3'd6 : 3'd7)) begin
            bit_d   = '0;
            state_d = short_q ? ST_EOF0 : ST_PAR;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PAR: begin
        // Next byte goes to a holding register so the parity being sent stays intact.
        if (hs) begin
          nxt_data_d = s_data;
          nxt_last_d = s_last;
          nxt_vld_d  = 1'b1;
        end
        if (slot_end) begin
          prev_d    = cur_bit;
          nxt_vld_d = 1'b0;
          if (last_q) begin
            state_d = ST_EOF0;
          end else if (nxt_vld_q || hs) begin
            data_d  = nxt_vld_q ? nxt_data_q : s_data;
            last_d  = nxt_vld_q ? nxt_last_q : s_last;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_EOF0;
          end
        end
      end
      ST_EOF0: begin
        if (slot_end) begin
          prev_d  = 1'b0;
          state_d = ST_EOF1;
        end
      end
      ST_EOF1: begin
        if (slot_end) begin
          done_d  = 1'b1;
          txerr_d = err_q;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle values.
    case (state_d)
      ST_DATA: new_bit = data_d[bit_d];
      ST_PAR:  new_bit = ~^data_d;
      default: new_bit = 1'b0;
    endcase

    case (state_d)
      ST_SOF:  pause_d = (cnt_d < Z_END);
      ST_DATA, ST_PAR, ST_EOF0:
        pause_d = new_bit ? ((cnt_d >= X_BEG) && (cnt_d < X_END))
                          : (!prev_d && (cnt_d < Z_END));
      default: pause_d = 1'b0;
    endcase

    ready_d = (state_d == ST_IDLE) ||
              ((state_d == ST_PAR) && !last_d && !nxt_vld_d);
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_nfca_tx_frame.sv
// Self-checking bench for nfca_tx_frame: directed NFC-A frames plus random
// bytes, compared cycle by cycle against a slot-level Modified-Miller model.
module tb_nfca_tx_frame;
  localparam int BIT   = 768;
  localparam int PAUSE = 192;
  localparam int SY = 0, SX = 1, SZ = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_short = 1'b0;
  logic       tx_pause, tx_busy, tx_done, tx_err;

  nfca_tx_frame #(.BIT_CLKS(BIT), .PAUSE_CLKS(PAUSE)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_short(s_short),
    .tx_pause(tx_pause), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;
  int done_cnt = 0;
  logic [7:0] fbytes[$];
  int foff[$];
  int sym[$];
  int acc_t[$];
  int pstart[$];

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Logical bit stream of the frame, then Miller symbols from the 0/1 history.
  function automatic void build_syms(input int nsent, input bit shrt);
    bit lb[$];
    bit prv;
    sym.delete();
    for (int i = 0; i < nsent; i++) begin
      for (int b = 0; b < (shrt ? 7 : 8); b++) lb.push_back(fbytes[i][b]);
      if (!shrt) lb.push_back(($countones(fbytes[i]) % 2) == 0);
    end
    lb.push_back(1'b0);
    sym.push_back(SZ);
    prv = 1'b0;
    foreach (lb[k]) begin
      if (lb[k]) sym.push_back(SX);
      else       sym.push_back(prv ? SY : SZ);
      prv = lb[k];
    end
    sym.push_back(SY);
  endfunction

  function automatic bit exp_pause(input int t);
    int s = t / BIT;
    int c = t % BIT;
    if (s >= sym.size()) return 1'b0;
    if (sym[s] == SX) return (c >= BIT / 2) && (c < BIT / 2 + PAUSE);
    if (sym[s] == SZ) return c < PAUSE;
    return 1'b0;
  endfunction

  task automatic run_frame(input string tag, input bit shrt, input bit hold,
                           input bit underrun, input int slots, input bit exp_err);
    int n = fbytes.size();
    int idx, w, mism, busy_bad, done_t, npx;
    bit lastp, err_at, busy_at, rdy_at;
    build_syms(n, shrt);
    acc_t.delete();
    pstart.delete();
    mism = 0; busy_bad = 0; done_t = -1; lastp = 1'b0;
    err_at = 1'b0; busy_at = 1'b1; rdy_at = 1'b0;

    @(negedge clk);
    s_valid = 1'b1; s_data = fbytes[0]; s_short = shrt;
    s_last = (n == 1) && !underrun;
    w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_ready"}, int'(s_ready === 1'b1), 1);
    idx = 1;

    for (int t = 0; t < slots * BIT + 200; t++) begin
      @(negedge clk);
      if (tx_pause !== exp_pause(t)) mism++;
      if (tx_pause === 1'b1 && !lastp) pstart.push_back(t);
      lastp = (tx_pause === 1'b1);
      if (tx_done === 1'b1) begin
        done_t = t; err_at = tx_err; busy_at = tx_busy; rdy_at = s_ready;
        s_valid = 1'b0;
        break;
      end
      if (tx_busy !== 1'b1) busy_bad++;
      s_short = 1'b0;
      if (idx < n) begin
        s_valid = hold || (t >= foff[idx]);
        s_data  = fbytes[idx];
        s_last  = (idx == n - 1) && !underrun;
      end else begin
        s_valid = hold;
        s_data  = 8'hFF;
        s_last  = 1'b1;
      end
      if (s_valid && s_ready === 1'b1) begin
        acc_t.push_back(t);
        idx++;
      end
    end
    s_valid = 1'b0;

    npx = 0;
    foreach (sym[k]) if (sym[k] != SY) npx++;
    chk({tag, "_wave_mismatch_cycles"}, mism, 0);
    chk({tag, "_pause_count"}, pstart.size(), npx);
    chk({tag, "_done_time"}, done_t, slots * BIT);
    chk({tag, "_err"}, int'(err_at), int'(exp_err));
    chk({tag, "_busy_gap"}, busy_bad, 0);
    chk({tag, "_busy_at_done"}, int'(busy_at), 0);
    chk({tag, "_ready_at_done"}, int'(rdy_at), 1);
    chk({tag, "_bytes_taken"}, acc_t.size(), n - 1);
    for (int i = 0; i < acc_t.size() && i < n - 1; i++)
      chk({tag, "_accept_time"}, acc_t[i],
          (hold || foff[i+1] < 9 * (i + 1) * BIT) ? 9 * (i + 1) * BIT : foff[i+1]);
  endtask

  int reqa_exp[7] = '{0, 768, 1920, 2688, 3840, 4992, 6144};
  int dc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pause", int'(tx_pause), 0);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_err", int'(tx_err), 0);
    chk("rst_ready", int'(s_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(s_ready), 1);

    // REQA short frame
    fbytes = '{8'h26}; foff = '{0};
    run_frame("reqa", 1'b1, 1'b0, 1'b0, 10, 1'b0);
    chk("reqa_npause", pstart.size(), 7);
    for (int i = 0; i < 7; i++)
      chk("reqa_pause_start", (i < pstart.size()) ? pstart[i] : -1, reqa_exp[i]);

    // ANTICOLLISION with s_valid held high
    fbytes = '{8'h93, 8'h20}; foff = '{0, 0};
    run_frame("anticoll", 1'b0, 1'b1, 1'b0, 21, 1'b0);

    // all-zero byte, s_valid held high in non-accepting states
    fbytes = '{8'h00}; foff = '{0};
    run_frame("zeros", 1'b0, 1'b1, 1'b0, 12, 1'b0);
    chk("zeros_npause", pstart.size(), 10);

    // underrun after one byte
    fbytes = '{8'hAA}; foff = '{0};
    run_frame("underrun", 1'b0, 1'b0, 1'b1, 12, 1'b1);

    // reset during the DATA pause of bit 1 of a REQA
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h26; s_short = 1'b1; s_last = 1'b0;
    dc = 0;
    while (s_ready !== 1'b1 && dc < 50) begin
      @(negedge clk);
      dc++;
    end
    repeat (2001) @(negedge clk);
    s_valid = 1'b0; s_short = 1'b0;
    chk("mid_pause_before_rst", int'(tx_pause), 1);
    dc = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pause", int'(tx_pause), 0);
    chk("mid_rst_busy", int'(tx_busy), 0);
    chk("mid_rst_ready", int'(s_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_back", int'(s_ready), 1);
    chk("mid_rst_no_done", done_cnt, dc);
    fbytes = '{8'h26}; foff = '{0};
    run_frame("reqa_after_rst", 1'b1, 1'b0, 1'b0, 10, 1'b0);

    // random two-byte frame, second byte offered late within PAR
    fbytes = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    foff = '{0, 9 * BIT + int'($urandom_range(0, BIT - 1))};
    run_frame("rand2", 1'b0, 1'b0, 1'b0, 21, 1'b0);

    // random short frame
    fbytes = '{8'($urandom_range(0, 127))}; foff = '{0};
    run_frame("rand_short", 1'b1, 1'b0, 1'b0, 10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
